pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates the EX-stage forwarding selects.
- Runs a data-memory wait handshake that freezes the pipeline while a load or store in the MEM stage is outstanding.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the MIPS 5-stage pipeline hazard controller.
//   state_t    : sequencing FSM states (RUN, MEM_WAIT)
//   fwd_sel_t  : EX-stage ALU operand source select
//   REG_ZERO   : architectural $zero, never a hazard source
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forwarding compare for one EX-stage ALU operand.
// Ports:
//   src_i            source register held in ID/EX
//   mem_rd_i/_we_i   EX/MEM destination and reg_write
//   wb_rd_i/_we_i    MEM/WB destination and reg_write
//   sel_o            operand select; EX/MEM has priority over MEM/WB
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_we_i,
  output fwd_sel_t   sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_we_i && (mem_rd_i != REG_ZERO) && (mem_rd_i == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (wb_we_i && (wb_rd_i != REG_ZERO) && (wb_rd_i == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Drives stage-register enables/flushes, EX forwarding selects, and a
// data-memory wait handshake that freezes the pipe while MEM is busy.
// Build option: define PIPE_FWD_EN to enable forwarding (only load-use
// stalls remain); otherwise fwd_a/fwd_b are 00 and any RAW against EX or
// MEM stalls (register file writes first half, reads second half).
// Ports:
//   clk, rst (async, active-high)
//   id_*       : ID instruction sources;  ex_* : ID/EX fields
//   mem_*      : EX/MEM fields;  wb_* : MEM/WB fields
//   branch_taken, dmem_ready : control inputs
//   pc_en, ifid_en, idex_en, exmem_en : load enables
//   ifid_flush, idex_flush, exmem_flush, memwb_bubble : bubble controls
//   fwd_a, fwd_b : ALU operand selects;  dmem_req : memory request
//   mem_err : sticky timeout flag;  stall_cycles : saturating pc_en=0 count
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_access,
  input  logic             branch_taken,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

`ifdef PIPE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic     freeze;
  logic     load_use_hit;
  logic     raw_hit;
  logic     hazard;
  fwd_sel_t fwd_a_sel, fwd_b_sel;

  // Forwarding compares; with forwarding disabled the writer enables are
  // masked so the selects can only resolve to the register file.
  fwd_unit u_fwd_a (
    .src_i    (ex_rs),
    .mem_rd_i (mem_rd),
    .mem_we_i (FWD_ON && mem_reg_write),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (FWD_ON && wb_reg_write),
    .sel_o    (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .src_i    (ex_rt),
    .mem_rd_i (mem_rd),
    .mem_we_i (FWD_ON && mem_reg_write),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (FWD_ON && wb_reg_write),
    .sel_o    (fwd_b_sel)
  );

  assign fwd_a    = rst ? FWD_RF : fwd_a_sel;
  assign fwd_b    = rst ? FWD_RF : fwd_b_sel;
  assign dmem_req = mem_access;
  assign mem_err  = mem_err_q;
  assign stall_cycles = stall_q;

  // Load in EX feeding an ID source: one bubble even with forwarding.
  assign load_use_hit = ex_mem_read && (ex_rd != REG_ZERO) &&
                        ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // Without forwarding any pending write in EX or MEM blocks ID.
  assign raw_hit =
    ((id_rs != REG_ZERO) &&
     ((ex_reg_write && (ex_rd == id_rs)) || (mem_reg_write && (mem_rd == id_rs)))) ||
    (id_uses_rt && (id_rt != REG_ZERO) &&
     ((ex_reg_write && (ex_rd == id_rt)) || (mem_reg_write && (mem_rd == id_rt))));

  assign hazard = FWD_ON ? load_use_hit : raw_hit;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    freeze       = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_access && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
          // Abort: flag the error and release exactly as a ready would.
          mem_err_d  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Branch and hazard checks are masked by the freeze and therefore
    // re-evaluated naturally on the release cycle.
    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    if (rst) begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=16, CNT_W=4 so the
// stall counter saturates within a short run). Expectations follow the
// PIPE_FWD_EN build option.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, memwb_bubble}
  localparam logic [7:0] CTL_RUN    = 8'b1111_0000;
  localparam logic [7:0] CTL_STALL  = 8'b0011_0100;
  localparam logic [7:0] CTL_BRANCH = 8'b1111_1110;
  localparam logic [7:0] CTL_FROZEN = 8'b0000_0001;

  logic       clk, rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rt, ex_mem_read, ex_reg_write, mem_reg_write;
  logic       mem_access, branch_taken, wb_reg_write, dmem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       dmem_req, mem_err;
  logic [3:0] stall_cycles;

  int vectors;
  int miscompares;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_access(mem_access), .branch_taken(branch_taken),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_req(dmem_req), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {pc_en, ifid_en, idex_en, exmem_en,
            ifid_flush, idex_flush, exmem_flush, memwb_bubble};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_access = 1'b0;
    branch_taken = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // Advance past the next rising edge; inputs change 1 time unit later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;

    // Reset gates everything, even with a pending memory op and a forward match.
    rst = 1'b1;
    idle();
    mem_access = 1'b1; ex_rs = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
    #2;
    chk("reset_ctl",   16'(ctl()), 16'(CTL_RUN));
    chk("reset_fwd_a", 16'(fwd_a), 16'd0);
    chk("reset_stall", 16'(stall_cycles), 16'd0);
    chk("reset_err",   16'(mem_err), 16'd0);

    @(negedge clk);
    rst = 1'b0;
    idle();
    next();
    @(negedge clk);
    chk("idle_ctl", 16'(ctl()), 16'(CTL_RUN));
    chk("idle_req", 16'(dmem_req), 16'd0);
    next();

    // lw $2 in EX, add in ID reads $2.
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd2; id_rs = 5'd2;
    @(negedge clk);
    chk("loaduse_ctl", 16'(ctl()), 16'(CTL_STALL));
    next();

    // Bubble in EX, lw now in MEM.
    idle();
    mem_rd = 5'd2; mem_reg_write = 1'b1; id_rs = 5'd2;
    @(negedge clk);
    chk("lw_in_mem_ctl", 16'(ctl()), 16'(FWD ? CTL_RUN : CTL_STALL));
    next();

    // add in EX, lw in WB.
    idle();
    ex_rs = 5'd2; wb_rd = 5'd2; wb_reg_write = 1'b1;
    @(negedge clk);
    chk("fwd_a_memwb", 16'(fwd_a), FWD ? 16'd2 : 16'd0);
    chk("stall_cnt_1", 16'(stall_cycles), FWD ? 16'd1 : 16'd2);
    next();

    // Both later stages write $5: EX/MEM wins.
    idle();
    ex_rs = 5'd5; ex_rt = 5'd3;
    mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    @(negedge clk);
    chk("fwd_a_exmem_prio", 16'(fwd_a), FWD ? 16'd1 : 16'd0);
    chk("fwd_b_nomatch",    16'(fwd_b), 16'd0);
    chk("fwd_ctl",          16'(ctl()), 16'(CTL_RUN));
    next();

    // $zero is never forwarded.
    idle();
    mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd0; wb_reg_write = 1'b1;
    @(negedge clk);
    chk("fwd_b_zero", 16'(fwd_b), 16'd0);
    chk("fwd_a_zero", 16'(fwd_a), 16'd0);
    next();

    // EX/MEM write to another reg, MEM/WB matches rt.
    idle();
    ex_rt = 5'd9; mem_rd = 5'd8; mem_reg_write = 1'b1; wb_rd = 5'd9; wb_reg_write = 1'b1;
    @(negedge clk);
    chk("fwd_b_memwb", 16'(fwd_b), FWD ? 16'd2 : 16'd0);
    next();

    // Branch taken beats a simultaneous load-use.
    idle();
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    @(negedge clk);
    chk("branch_ctl", 16'(ctl()), 16'(CTL_BRANCH));
    next();
    idle();
    @(negedge clk);
    chk("branch_no_stall_cnt", 16'(stall_cycles), FWD ? 16'd1 : 16'd2);
    next();

    // rt is ignored unless the ID instruction reads it.
    idle();
    id_rt = 5'd6; ex_rd = 5'd6; ex_reg_write = 1'b1;
    @(negedge clk);
    chk("rt_unused_ctl", 16'(ctl()), 16'(CTL_RUN));
    next();
    id_uses_rt = 1'b1;
    @(negedge clk);
    chk("rt_alu_raw_ctl", 16'(ctl()), 16'(FWD ? CTL_RUN : CTL_STALL));
    next();
    ex_mem_read = 1'b1;
    @(negedge clk);
    chk("rt_loaduse_ctl", 16'(ctl()), 16'(CTL_STALL));
    next();
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    chk("zero_dest_no_stall", 16'(ctl()), 16'(CTL_RUN));
    next();

    // Memory wait: 4 frozen cycles, then release on ready with a branch.
    idle();
    mem_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        ex_rd = 5'd4; id_rs = 5'd4;
      end else begin
        branch_taken = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        ex_rd = 5'd0; id_rs = 5'd0;
      end
      @(negedge clk);
      chk($sformatf("memwait_frozen_%0d", i), 16'(ctl()), 16'(CTL_FROZEN));
      chk($sformatf("memwait_req_%0d", i),    16'(dmem_req), 16'd1);
      next();
    end
    branch_taken = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0; id_rs = 5'd0;
    dmem_ready = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    chk("memwait_release_branch", 16'(ctl()), 16'(CTL_BRANCH));
    next();
    idle();
    @(negedge clk);
    chk("memwait_stall_cnt", 16'(stall_cycles), FWD ? 16'd6 : 16'd8);
    next();

    // Zero-latency access.
    mem_access = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    chk("zero_latency_ctl", 16'(ctl()), 16'(CTL_RUN));
    chk("zero_latency_req", 16'(dmem_req), 16'd1);
    next();

    // Timeout: 16 frozen cycles, release on the 17th, sticky error.
    idle();
    mem_access = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("timeout_frozen_%0d", i), 16'(ctl()), 16'(CTL_FROZEN));
      if (i == 15) chk("timeout_err_before", 16'(mem_err), 16'd0);
      next();
    end
    @(negedge clk);
    chk("timeout_release", 16'(ctl()), 16'(CTL_RUN));
    next();
    idle();
    @(negedge clk);
    chk("timeout_err_set",  16'(mem_err), 16'd1);
    chk("stall_saturated",  16'(stall_cycles), 16'd15);
    chk("timeout_resume",   16'(ctl()), 16'(CTL_RUN));
    next();
    next();
    @(negedge clk);
    chk("timeout_err_held", 16'(mem_err), 16'd1);
    next();

    // Reset while in MEM_WAIT with wait_cnt = 3.
    mem_access = 1'b1;
    next();
    next();
    next();
    @(negedge clk);
    chk("pre_reset_frozen", 16'(ctl()), 16'(CTL_FROZEN));
    #1 rst = 1'b1;
    #1;
    chk("midwait_reset_ctl",   16'(ctl()), 16'(CTL_RUN));
    chk("midwait_reset_stall", 16'(stall_cycles), 16'd0);
    chk("midwait_reset_err",   16'(mem_err), 16'd0);
    #1 rst = 1'b0;
    idle();
    next();
    @(negedge clk);
    chk("post_reset_run", 16'(ctl()), 16'(CTL_RUN));
    chk("post_reset_err", 16'(mem_err), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
